// File: rtl/dmem_responder.sv
// Single-port 64-bit-word data memory with a fixed-latency request/response handshake.
// Loads are extended per RISC-V funct3; stores write only the addressed bytes.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on an edge with req_valid && req_ready;
  // a response transfers on an edge with resp_valid && resp_ready.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;

  logic [63:0] r_mem [0:(1 << (ADDR_WIDTH - 3)) - 1];

  logic [2:0]            w_lane;
  logic [ADDR_WIDTH-4:0] w_idx;
  logic [7:0]            w_bmask8;
  logic [2:0]            w_align;
  logic [7:0]            w_be;
  logic [63:0]           w_bmask;
  logic [63:0]           w_word;
  logic [63:0]           w_shift;
  logic [63:0]           w_wsh;
  logic [63:0]           w_newword;
  logic [63:0]           w_load;
  logic                  w_oor;
  logic                  w_misal;
  logic                  w_illegal;
  logic                  w_err;
  logic                  w_exec;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_state  = r_state;
  assign w_exec     = (r_state == S_BUSY) && (r_cnt == 4'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Access decode, all from the fields latched at accept.
  always_comb begin
    w_lane   = r_addr[2:0];
    w_idx    = r_addr[ADDR_WIDTH-1:3];
    w_oor    = |r_addr[63:ADDR_WIDTH];
    w_bmask8 = 8'h01;
    w_align  = 3'b000;
    case (r_size[1:0])
      2'd0: begin w_bmask8 = 8'h01; w_align = 3'b000; end
      2'd1: begin w_bmask8 = 8'h03; w_align = 3'b001; end
      2'd2: begin w_bmask8 = 8'h0F; w_align = 3'b011; end
      default: begin w_bmask8 = 8'hFF; w_align = 3'b111; end
    endcase
    w_misal   = |(w_lane & w_align);
    w_illegal = r_write ? r_size[2] : (r_size == 3'b111);
    w_err     = w_oor | w_misal | w_illegal;

    w_word  = r_mem[w_idx];
    w_shift = w_word >> {w_lane, 3'b000};
    w_be    = w_bmask8 << w_lane;
    w_bmask = '0;
    for (int i = 0; i < 8; i++) w_bmask[8*i +: 8] = {8{w_be[i]}};
    w_wsh     = r_wdata << {w_lane, 3'b000};
    w_newword = (w_word & ~w_bmask) | (w_wsh & w_bmask);

    case (r_size)
      3'b000:  w_load = {{56{w_shift[7]}},  w_shift[7:0]};
      3'b001:  w_load = {{48{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_load = {{32{w_shift[31]}}, w_shift[31:0]};
      3'b011:  w_load = w_shift;
      3'b100:  w_load = {56'd0, w_shift[7:0]};
      3'b101:  w_load = {48'd0, w_shift[15:0]};
      3'b110:  w_load = {32'd0, w_shift[31:0]};
      default: w_load = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 64'd0;
      r_size  <= 3'd0;
      r_wdata <= 64'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write <= req_write;
          r_addr  <= req_addr;
          r_size  <= req_size;
          r_wdata <= req_wdata;
          r_cnt   <= 4'(LATENCY - 1);
        end
        S_BUSY: if (r_cnt == 4'd0) begin
          r_err   <= w_err;
          r_rdata <= (w_err || r_write) ? 64'd0 : w_load;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: if (resp_ready) begin
          r_rdata <= 64'd0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; reset only blocks an uncommitted store.
  always_ff @(posedge clk) begin
    if (!rst && w_exec && r_write && !w_err) r_mem[w_idx] <= w_newword;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, load extension, byte stores,
// error cases, response back-pressure and reset mid-transaction.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge with the responder idle.
  task automatic txn(input string tag, input logic w, input logic [63:0] a, input logic [2:0] s,
                     input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err);
    int n;
    check($sformatf("%s_rdy", tag), {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s_lat", tag), 64'(n), 64'd2);
    check($sformatf("%s_rdata", tag), resp_rdata, exp_rd);
    check($sformatf("%s_err", tag), {63'd0, resp_err}, {63'd0, exp_err});
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check($sformatf("%s_done", tag), {63'd0, resp_valid}, 64'd0);
  endtask

  logic [63:0] held;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", {63'd0, resp_err}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    txn("pre_sd20", 1, 64'h20, 3'b011, 64'h0, 64'h0, 0);
    txn("sd10", 1, 64'h10, 3'b011, 64'h8877665544332211, 64'h0, 0);
    txn("ld10", 0, 64'h10, 3'b011, 64'h0, 64'h8877665544332211, 0);
    txn("lb17", 0, 64'h17, 3'b000, 64'h0, 64'hFFFFFFFFFFFFFF88, 0);
    txn("lbu17", 0, 64'h17, 3'b100, 64'h0, 64'h88, 0);
    txn("lh16", 0, 64'h16, 3'b001, 64'h0, 64'hFFFFFFFFFFFF8877, 0);
    txn("lhu16", 0, 64'h16, 3'b101, 64'h0, 64'h8877, 0);
    txn("lwu14", 0, 64'h14, 3'b110, 64'h0, 64'h88776655, 0);
    txn("lw14", 0, 64'h14, 3'b010, 64'h0, 64'hFFFFFFFF88776655, 0);
    txn("lw10", 0, 64'h10, 3'b010, 64'h0, 64'h44332211, 0);
    txn("sb11", 1, 64'h11, 3'b000, 64'hAB, 64'h0, 0);
    txn("ld10_sb", 0, 64'h10, 3'b011, 64'h0, 64'h887766554433AB11, 0);
    txn("sh12", 1, 64'h12, 3'b001, 64'hFFFFBEEF, 64'h0, 0);
    txn("ld10_sh", 0, 64'h10, 3'b011, 64'h0, 64'h88776655BEEFAB11, 0);

    txn("lw12_mis", 0, 64'h12, 3'b010, 64'h0, 64'h0, 1);
    txn("sd400_oor", 1, 64'h400, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1);
    txn("ld0_after_oor", 0, 64'h0, 3'b011, 64'h0, 64'h0, 0);
    txn("ld_f7", 0, 64'h10, 3'b111, 64'h0, 64'h0, 1);
    txn("ld_hibit", 0, 64'h8000000000000010, 3'b011, 64'h0, 64'h0, 1);
    txn("st_f4", 1, 64'h10, 3'b100, 64'h5555, 64'h0, 1);
    txn("sw16_mis", 1, 64'h16, 3'b010, 64'h77777777, 64'h0, 1);
    txn("ld10_err_nochg", 0, 64'h10, 3'b011, 64'h0, 64'h88776655BEEFAB11, 0);

    // Back-pressure: response held while a competing store is offered.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 3'b011;
    @(posedge clk); #1;
    req_write = 1'b1; req_wdata = 64'hDEADBEEFDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    held = 64'h88776655BEEFAB11;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_valid%0d", i), {63'd0, resp_valid}, 64'd1);
      check($sformatf("hold_rdata%0d", i), resp_rdata, held);
      check($sformatf("hold_rdy%0d", i), {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("hold_rel_valid", {63'd0, resp_valid}, 64'd0);
    check("hold_rel_ready", {63'd0, req_ready}, 64'd1);
    check("hold_rel_rdata", resp_rdata, 64'd0);
    txn("ld10_after_hold", 0, 64'h10, 3'b011, 64'h0, held, 0);

    // resp_ready while idle must not disturb anything.
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("idle_rr_ready", {63'd0, req_ready}, 64'd1);

    // Reset on the first BUSY edge drops the uncommitted store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_size = 3'b011;
    req_wdata = 64'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_busy", {62'd0, dbg_state}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    check("rst_mid_valid", {63'd0, resp_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_quiet", {63'd0, resp_valid}, 64'd0);
    txn("ld20_after_rst", 0, 64'h20, 3'b011, 64'h0, 64'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width of storage (capacity 2^ADDR_WIDTH bytes, 64-bit words).
REQ-002 Parameter LATENCY, default 2, clock edges from request accept to response valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept; high only in IDLE.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  64  byte address.
REQ-009 req_size  input  3  RISC-V funct3 of load/store.
REQ-010 req_wdata  input  64  store data, right-aligned.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts response.
REQ-013 resp_rdata  output  64  load result, extended per funct3; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected (misaligned, out of range, illegal size).

Function
REQ-015 States IDLE, BUSY and RESP shall be used; req_ready = (state==IDLE).
REQ-016 Accept occurs on an edge with req_valid && req_ready; all req_* fields latched at that edge; state -> BUSY, counter = LATENCY-1.
REQ-017 In BUSY, counter decrements each edge; on the edge with counter==0 the access executes and state -> RESP, so resp_valid rises exactly LATENCY edges after accept.
REQ-018 Load sizes: 000 LB, 001 LH, 010 LW, 011 LD sign-extend to 64 bits; 100 LBU, 101 LHU, 110 LWU zero-extend; 111 illegal.
REQ-019 Store sizes: 000 SB, 001 SH, 010 SW, 011 SD write the low 1/2/4/8 bytes of req_wdata; 100-111 illegal.
REQ-020 Byte order is little-endian; byte lane = addr[2:0]; word index = addr[ADDR_WIDTH-1:3].
REQ-021 Misaligned access (addr not a multiple of access size) shall set resp_err.
REQ-022 Out-of-range access (any of addr[63:ADDR_WIDTH] nonzero) shall set resp_err.
REQ-023 Any erroring request shall not modify storage and shall return resp_rdata = 0.
REQ-024 A store commits on the BUSY->RESP edge and modifies only the addressed bytes.
REQ-025 In RESP, resp_valid, resp_rdata and resp_err hold stable until the edge with resp_ready high; that edge -> IDLE, outputs cleared.
REQ-026 No new request is accepted in BUSY or RESP; req_valid is ignored there.
REQ-027 A load following a store to the same bytes shall return the stored value.
REQ-028 resp_ready asserted while resp_valid is low shall have no effect.

Reset
REQ-029 rst has priority over all other inputs on the same edge.
REQ-030 After the reset edge: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, counter 0.
REQ-031 Reset in BUSY or RESP discards the pending transaction; a store not yet committed shall not be written.
REQ-032 Storage contents are not cleared by reset; simulation initial contents are all zero.

Verification (ADDR_WIDTH=10, LATENCY=2)
REQ-033 SD addr 0x10 data 0x8877665544332211, then LD 0x10 -> resp_valid 2 edges after each accept, rdata 0x8877665544332211, err 0.
REQ-034 After REQ-033: LB 0x17 -> 0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x88; LH 0x16 -> 0xFFFFFFFFFFFF8877; LWU 0x14 -> 0x88776655.
REQ-035 SB 0x11 data 0xAB, then LD 0x10 -> 0x887766554433AB11 (only byte 1 changed).
REQ-036 LW 0x12 -> err 1, rdata 0; SD 0x400 -> err 1, storage unchanged; load funct3 111 -> err 1.
REQ-037 Hold resp_ready low 5 cycles after resp_valid -> outputs stable, req_ready 0, req_valid ignored; resp_ready high -> IDLE next edge.
REQ-038 SD 0x20 data 0x1234, rst asserted on first BUSY edge -> IDLE, resp_valid 0; subsequent LD 0x20 -> 0.
